// File: rtl/alu_issue_unit_pkg.sv
// Shared constants and types for the ALU issue front end: RV32I opcode/funct7
// encodings, ALU operation codes, issue FSM states and the decoded-op record.
package alu_issue_unit_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_CMP,
        ST_HOLD
    } issue_state_t;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       is_slt;
        logic       is_sltu;
        logic       illegal;
        logic       use_imm;
        logic       is_shift;
    } dec_op_t;

endpackage

// File: rtl/alu_issue_unit_if.sv
// Instruction-in / result-out handshake bundle between a producer/consumer
// (master) and the issue unit (slave).
interface alu_issue_unit_if #(
    parameter int WORD_BITWIDTH = 32
);
    logic                     in_valid;
    logic                     in_ready;
    logic [6:0]               opcode;
    logic [2:0]               funct3;
    logic [6:0]               funct7;
    logic [WORD_BITWIDTH-1:0] rs1_val;
    logic [WORD_BITWIDTH-1:0] rs2_val;
    logic [WORD_BITWIDTH-1:0] imm;
    logic                     out_valid;
    logic                     out_ready;
    logic [WORD_BITWIDTH-1:0] out_result;
    logic                     out_zero;
    logic                     out_illegal;

    modport master (
        output in_valid, opcode, funct3, funct7, rs1_val, rs2_val, imm, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_illegal
    );

    modport slave (
        input  in_valid, opcode, funct3, funct7, rs1_val, rs2_val, imm, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_illegal
    );
endinterface

// File: rtl/alu.sv
// Team integer ALU: purely combinational, 4-bit operation code select.
module alu
    import alu_issue_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result
);
    always_comb begin
        o_result = '0;
        case (i_op)
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_ADD: o_result = i_a + i_b;
            ALU_XOR: o_result = i_a ^ i_b;
            ALU_SLL: o_result = i_a << i_b;
            ALU_SRL: o_result = i_a >> i_b;
            ALU_SUB: o_result = i_a - i_b;
            default: o_result = '0;
        endcase
    end
endmodule

// File: rtl/alu_issue_unit_alu_op_decode.sv
// Maps RV32I OP / OP-IMM opcode, funct3 and funct7 onto an ALU operation plus
// the compare, immediate, shift and illegal qualifiers.
module alu_op_decode
    import alu_issue_unit_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic [6:0] i_funct7,
    output dec_op_t    o_dec
);
    always_comb begin
        o_dec        = '0;
        o_dec.alu_op = ALU_ADD;
        if (i_opcode == OPC_OP) begin
            if (i_funct7 == F7_BASE) begin
                case (i_funct3)
                    3'b000: o_dec.alu_op = ALU_ADD;
                    3'b001: begin o_dec.alu_op = ALU_SLL; o_dec.is_shift = 1'b1; end
                    3'b010: begin o_dec.alu_op = ALU_SUB; o_dec.is_slt   = 1'b1; end
                    3'b011: begin o_dec.alu_op = ALU_SUB; o_dec.is_sltu  = 1'b1; end
                    3'b100: o_dec.alu_op = ALU_XOR;
                    3'b101: begin o_dec.alu_op = ALU_SRL; o_dec.is_shift = 1'b1; end
                    3'b110: o_dec.alu_op = ALU_OR;
                    default: o_dec.alu_op = ALU_AND;
                endcase
            end else if (i_funct7 == F7_ALT && i_funct3 == 3'b000) begin
                o_dec.alu_op = ALU_SUB;
            end else begin
                o_dec.illegal = 1'b1;
            end
        end else if (i_opcode == OPC_OP_IMM) begin
            o_dec.use_imm = 1'b1;
            // funct7 only qualifies the shift-immediate forms; SRAI is not supported
            case (i_funct3)
                3'b000: o_dec.alu_op = ALU_ADD;
                3'b001: begin
                    o_dec.alu_op   = ALU_SLL;
                    o_dec.is_shift = 1'b1;
                    o_dec.illegal  = (i_funct7 != F7_BASE);
                end
                3'b010: begin o_dec.alu_op = ALU_SUB; o_dec.is_slt  = 1'b1; end
                3'b011: begin o_dec.alu_op = ALU_SUB; o_dec.is_sltu = 1'b1; end
                3'b100: o_dec.alu_op = ALU_XOR;
                3'b101: begin
                    o_dec.alu_op   = ALU_SRL;
                    o_dec.is_shift = 1'b1;
                    o_dec.illegal  = (i_funct7 != F7_BASE);
                end
                3'b110: o_dec.alu_op = ALU_OR;
                default: o_dec.alu_op = ALU_AND;
            endcase
        end else begin
            o_dec.illegal = 1'b1;
        end
    end
endmodule

// File: rtl/alu_issue_unit.sv
// Multi-cycle RV32I ALU issue front end: accepts one OP/OP-IMM instruction,
// runs it through the team ALU and holds the registered result until consumed.
module alu_issue_unit
    import alu_issue_unit_pkg::*;
#(
    parameter int WORD_BITWIDTH = 32,
    parameter int SHAMT_BITS    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_issue_unit_if.slave  bus
);
    issue_state_t r_state;
    issue_state_t w_state_next;

    dec_op_t                  w_dec;
    dec_op_t                  r_dec;
    logic [WORD_BITWIDTH-1:0] r_op_a;
    logic [WORD_BITWIDTH-1:0] r_op_b;
    logic [WORD_BITWIDTH-1:0] r_result;
    logic                     r_zero;
    logic                     r_illegal;

    logic                     w_accept;
    logic [WORD_BITWIDTH-1:0] w_op_b_sel;
    logic [WORD_BITWIDTH-1:0] w_op_b;
    logic [WORD_BITWIDTH-1:0] w_alu_result;
    logic                     w_less;

    alu_op_decode u_decode (
        .i_opcode (bus.opcode),
        .i_funct3 (bus.funct3),
        .i_funct7 (bus.funct7),
        .o_dec    (w_dec)
    );

    alu #(
        .WIDTH (WORD_BITWIDTH)
    ) u_alu (
        .i_op     (r_dec.alu_op),
        .i_a      (r_op_a),
        .i_b      (r_op_b),
        .o_result (w_alu_result)
    );

    assign w_accept   = bus.in_valid && (r_state == ST_IDLE);
    assign w_op_b_sel = w_dec.use_imm ? bus.imm : bus.rs2_val;
    assign w_op_b     = w_dec.is_shift
                      ? {{(WORD_BITWIDTH-SHAMT_BITS){1'b0}}, w_op_b_sel[SHAMT_BITS-1:0]}
                      : w_op_b_sel;

    // Differing signs decide the compare directly; otherwise the stored diff MSB does.
    // r_result holds A-B while in CMP.
    assign w_less = (r_op_a[WORD_BITWIDTH-1] != r_op_b[WORD_BITWIDTH-1])
                  ? (r_dec.is_slt ? r_op_a[WORD_BITWIDTH-1] : r_op_b[WORD_BITWIDTH-1])
                  : r_result[WORD_BITWIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_next = ST_EXEC;
            ST_EXEC: begin
                if (!r_dec.illegal && (r_dec.is_slt || r_dec.is_sltu)) begin
                    w_state_next = ST_CMP;
                end else begin
                    w_state_next = ST_HOLD;
                end
            end
            ST_CMP:  w_state_next = ST_HOLD;
            ST_HOLD: if (bus.out_ready) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (r_state == ST_IDLE);
        bus.out_valid = (r_state == ST_HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dec     <= '0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_dec  <= w_dec;
                        r_op_a <= bus.rs1_val;
                        r_op_b <= w_op_b;
                    end
                end
                ST_EXEC: begin
                    if (r_dec.illegal) begin
                        r_result  <= '0;
                        r_zero    <= 1'b1;
                        r_illegal <= 1'b1;
                    end else begin
                        r_result  <= w_alu_result;
                        r_illegal <= 1'b0;
                        if (!(r_dec.is_slt || r_dec.is_sltu)) begin
                            r_zero <= (w_alu_result == '0);
                        end
                    end
                end
                ST_CMP: begin
                    r_result <= {{(WORD_BITWIDTH-1){1'b0}}, w_less};
                    r_zero   <= ~w_less;
                end
                default: ;
            endcase
        end
    end

    assign bus.out_result  = r_result;
    assign bus.out_zero    = r_zero;
    assign bus.out_illegal = r_illegal;
endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed self-checking bench for alu_issue_unit: results, flags, latency,
// backpressure stability and asynchronous reset while holding a result.
module tb_alu_issue_unit;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] F7B    = 7'b0000000;
    localparam logic [6:0] F7A    = 7'b0100000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    alu_issue_unit_if #(.WORD_BITWIDTH(32)) u_if ();

    alu_issue_unit #(
        .WORD_BITWIDTH (32),
        .SHAMT_BITS    (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
        u_if.opcode   = opc;
        u_if.funct3   = f3;
        u_if.funct7   = f7;
        u_if.rs1_val  = a;
        u_if.rs2_val  = b;
        u_if.imm      = im;
        u_if.in_valid = 1'b1;
    endtask

    // Cycle 0 is the accepting cycle; latency counts edges until out_valid is seen.
    task automatic wait_result(input string tag, input int exp_lat, input logic [31:0] exp_res,
                               input logic exp_zero, input logic exp_ill);
        int cyc;
        check({tag, "_in_ready"}, u_if.in_ready, 1);
        @(posedge clk); #1;
        cyc = 1;
        u_if.in_valid = 1'b0;
        while (!u_if.out_valid && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_valid"},   u_if.out_valid, 1);
        check({tag, "_latency"}, cyc, exp_lat);
        check({tag, "_result"},  u_if.out_result, exp_res);
        check({tag, "_zero"},    u_if.out_zero, exp_zero);
        check({tag, "_illegal"}, u_if.out_illegal, exp_ill);
        check({tag, "_busy"},    u_if.in_ready, 0);
    endtask

    task automatic drain(input string tag);
        u_if.out_ready = 1'b1;
        @(posedge clk); #1;
        u_if.out_ready = 1'b0;
        check({tag, "_drop_valid"}, u_if.out_valid, 0);
        check({tag, "_idle_ready"}, u_if.in_ready, 1);
    endtask

    initial begin
        u_if.in_valid  = 1'b0;
        u_if.out_ready = 1'b0;
        u_if.opcode    = '0;
        u_if.funct3    = '0;
        u_if.funct7    = '0;
        u_if.rs1_val   = '0;
        u_if.rs2_val   = '0;
        u_if.imm       = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid",   u_if.out_valid, 0);
        check("rst_out_result",  u_if.out_result, 0);
        check("rst_out_zero",    u_if.out_zero, 0);
        check("rst_out_illegal", u_if.out_illegal, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", u_if.in_ready, 1);

        issue(OP, 3'b000, F7B, 32'h0000_0005, 32'h0000_000A, 32'h0);
        wait_result("add", 2, 32'h0000_000F, 1'b0, 1'b0);
        drain("add");

        issue(OP, 3'b000, F7A, 32'h1234_5678, 32'h1234_5678, 32'h0);
        wait_result("sub", 2, 32'h0000_0000, 1'b1, 1'b0);
        drain("sub");

        issue(OP, 3'b010, F7B, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0);
        wait_result("slt", 3, 32'h0000_0001, 1'b0, 1'b0);
        drain("slt");

        issue(OP, 3'b011, F7B, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0);
        wait_result("sltu", 3, 32'h0000_0000, 1'b1, 1'b0);
        drain("sltu");

        issue(OP, 3'b011, F7B, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0);
        wait_result("sltu_b_msb", 3, 32'h0000_0001, 1'b0, 1'b0);
        drain("sltu_b_msb");

        issue(OP_IMM, 3'b010, F7B, 32'h0000_0003, 32'hDEAD_BEEF, 32'h0000_0005);
        wait_result("slti_same_sign", 3, 32'h0000_0001, 1'b0, 1'b0);
        drain("slti_same_sign");

        issue(OP, 3'b101, F7B, 32'h8000_0000, 32'h0000_0021, 32'h0);
        wait_result("srl_mask", 2, 32'h4000_0000, 1'b0, 1'b0);
        drain("srl_mask");

        issue(OP, 3'b001, F7B, 32'h0000_0001, 32'h0000_001F, 32'h0);
        wait_result("sll", 2, 32'h8000_0000, 1'b0, 1'b0);
        drain("sll");

        issue(OP_IMM, 3'b100, F7B, 32'hFF00_FF00, 32'h0, 32'hFFFF_FFFF);
        wait_result("xori", 2, 32'h00FF_00FF, 1'b0, 1'b0);
        drain("xori");

        issue(OP, 3'b101, F7A, 32'h8000_0000, 32'h0000_0001, 32'h0);
        wait_result("sra_illegal", 2, 32'h0000_0000, 1'b1, 1'b1);
        drain("sra_illegal");

        issue(OP_IMM, 3'b101, F7A, 32'h8000_0000, 32'h0, 32'h0000_0401);
        wait_result("srai_illegal", 2, 32'h0000_0000, 1'b1, 1'b1);
        drain("srai_illegal");

        issue(LUI, 3'b000, F7B, 32'h0000_0005, 32'h0000_0005, 32'h0);
        wait_result("lui_illegal", 2, 32'h0000_0000, 1'b1, 1'b1);
        drain("lui_illegal");

        issue(OP_IMM, 3'b110, F7B, 32'h0000_00F0, 32'h1234_5678, 32'h0000_000F);
        wait_result("ori", 2, 32'h0000_00FF, 1'b0, 1'b0);
        // A new request while holding must be ignored and the result stay put.
        issue(OP, 3'b000, F7B, 32'h1, 32'h1, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold_valid",  u_if.out_valid, 1);
            check("hold_result", u_if.out_result, 32'h0000_00FF);
            check("hold_busy",   u_if.in_ready, 0);
        end
        u_if.in_valid = 1'b0;

        rst_n = 1'b0;
        #1;
        check("midrst_valid",  u_if.out_valid, 0);
        check("midrst_result", u_if.out_result, 0);
        check("midrst_ready",  u_if.in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(OP, 3'b000, F7B, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0);
        wait_result("post_rst_add", 2, 32'h8000_0000, 1'b0, 1'b0);
        drain("post_rst_add");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
